fft_tile_sched: RTL

Round-robin scheduler that shares one fft2D engine between NREQ tile loaders, such as the image-tile and kernel-tile buffers.
- Grants the engine to one requester at a time.
- Sequences a burst of ROWS row beats (valid/ready) into the engine.
- Waits for the engine's completion pulse, then reports which requester finished.
- Control only: the data mux lives outside and is steered by grant_id/row_idx.

---
 rtl/fft_tile_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fft_tile_sched.sv
// Round-robin scheduler sharing one fft2D engine among NREQ tile loaders: grant, ROWS-beat burst, wait for completion.
// Optional watchdog on the completion wait is enabled by defining FFT_SCHED_TIMEOUT_EN.
module fft_tile_sched #(
  parameter int NREQ   = 2,
  parameter int ROWS   = 8,
  parameter int IDXLEN = 3
`ifdef FFT_SCHED_TIMEOUT_EN
  ,
  parameter int TOLEN  = 10
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   grant,
  output logic [IDXLEN-1:0] grant_id,
  output logic [IDXLEN-1:0] row_idx,
  output logic              fftvalid,
  output logic              fftlast,
  input  logic              fft_ready,
  input  logic              fft_done,
  output logic              done,
  output logic [IDXLEN-1:0] done_id,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, FIN} state_t;

  localparam logic [IDXLEN-1:0] LAST_ROW = IDXLEN'(ROWS - 1);
  localparam logic [IDXLEN-1:0] LAST_REQ = IDXLEN'(NREQ - 1);

  state_t              r_state;
  logic [NREQ-1:0]     r_grant;
  logic [IDXLEN-1:0]   r_grant_id;
  logic [IDXLEN-1:0]   r_row_idx;
  logic                r_fftvalid;
  logic                r_done;
  logic [IDXLEN-1:0]   r_done_id;
  logic [IDXLEN-1:0]   r_rr;
  logic                r_done_seen;

  logic                w_found;
  logic [IDXLEN-1:0]   w_pick;
  logic                w_last_row;
  logic                w_wait_exit;

  // First requester at or after the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    int j;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(r_rr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_pick  = IDXLEN'(j);
      end
    end
  end

  assign w_last_row = (r_row_idx == LAST_ROW);

`ifdef FFT_SCHED_TIMEOUT_EN
  localparam logic [TOLEN-1:0] TO_LAST = TOLEN'((1 << TOLEN) - 2);
  logic [TOLEN-1:0] r_to_cnt;
  logic             r_err;
  logic             w_timeout;

  // Counter reaches 2^TOLEN-1 on the edge that ends this WAIT cycle.
  assign w_timeout   = (r_to_cnt == TO_LAST) && !fft_done && !r_done_seen;
  assign w_wait_exit = fft_done | r_done_seen | w_timeout;
  assign err         = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else if (r_state == STREAM) begin
      r_to_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_to_cnt <= r_to_cnt + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_wait_exit = fft_done | r_done_seen;
  assign err         = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_grant_id  <= '0;
      r_row_idx   <= '0;
      r_fftvalid  <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= '0;
      r_rr        <= '0;
      r_done_seen <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant    <= NREQ'(1) << w_pick;
            r_grant_id <= w_pick;
            r_row_idx  <= '0;
            r_fftvalid <= 1'b1;
            r_state    <= STREAM;
          end
        end
        STREAM: begin
          if (fft_done) r_done_seen <= 1'b1;
          if (r_fftvalid && fft_ready) begin
            if (w_last_row) begin
              r_fftvalid <= 1'b0;
              r_state    <= WAIT;
            end else begin
              r_row_idx <= r_row_idx + 1'b1;
            end
          end
        end
        WAIT: begin
          if (w_wait_exit) begin
            r_done    <= 1'b1;
            r_done_id <= r_grant_id;
            r_grant   <= '0;
            r_state   <= FIN;
          end
        end
        FIN: begin
          r_rr        <= (r_grant_id == LAST_REQ) ? '0 : r_grant_id + 1'b1;
          r_done_seen <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign row_idx  = r_row_idx;
  assign fftvalid = r_fftvalid;
  assign fftlast  = r_fftvalid & w_last_row;
  assign done     = r_done;
  assign done_id  = r_done_id;

endmodule
